// File: rtl/exibe_sequencia_if.sv
// Bus between the game's main control unit (master) and the LED sequence presenter (slave).
// The slave also drives the sequence-memory address and reads its combinational data.
interface exibe_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              parar;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] dado_memoria;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, parar, limite, dado_memoria,
    input  endereco, leds, ocupado, pronto, db_estado
  );

  modport slave (
    input  iniciar, parar, limite, dado_memoria,
    output endereco, leds, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/exibe_sequencia.sv
// Shows the stored sequence of the current round on the LEDs, item by item, from
// address 0 up to the round limit, each lit for T_LIGA clocks then dark for T_DESLIGA.
module exibe_sequencia #(
  parameter int T_LIGA    = 500,
  parameter int T_DESLIGA = 250,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4
) (
  input  logic            clock,
  input  logic            reset,
  exibe_sequencia_if.slave bus
);
  localparam int T_MAX   = (T_LIGA > T_DESLIGA) ? T_LIGA : T_DESLIGA;
  localparam int TIMER_W = $clog2(T_MAX) + 1;
  localparam logic [TIMER_W-1:0] LIGA_FIM    = TIMER_W'(T_LIGA - 1);
  localparam logic [TIMER_W-1:0] DESLIGA_FIM = TIMER_W'(T_DESLIGA - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    MOSTRA  = 3'd2,
    APAGA   = 3'd3,
    AVANCA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           estado;
  estado_t           estado_prox;
  logic [TIMER_W-1:0] timer;
  logic [ADDR_W-1:0]  endereco;
  logic [ADDR_W-1:0]  limite_reg;
  logic               liga_fim;
  logic               desliga_fim;

  assign liga_fim    = (timer == LIGA_FIM);
  assign desliga_fim = (timer == DESLIGA_FIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (bus.iniciar) estado_prox = CARREGA;
      CARREGA: estado_prox = MOSTRA;
      MOSTRA:  if (liga_fim) estado_prox = APAGA;
      // Limit compare happens before any increment, so endereco never wraps.
      APAGA:   if (desliga_fim) estado_prox = (endereco == limite_reg) ? FIM : AVANCA;
      AVANCA:  estado_prox = MOSTRA;
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
    if (bus.parar) estado_prox = OCIOSO;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer      <= '0;
      endereco   <= '0;
      limite_reg <= '0;
    end else if (bus.parar) begin
      timer <= '0;
    end else begin
      case (estado)
        CARREGA: begin
          endereco   <= '0;
          timer      <= '0;
          limite_reg <= bus.limite;
        end
        MOSTRA:  timer <= liga_fim ? '0 : timer + 1'b1;
        APAGA:   timer <= desliga_fim ? '0 : timer + 1'b1;
        AVANCA:  endereco <= endereco + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.leds      = '0;
    bus.db_estado = 4'hF;
    case (estado)
      OCIOSO:  bus.db_estado = 4'h0;
      CARREGA: bus.db_estado = 4'h1;
      MOSTRA: begin
        bus.db_estado = 4'h2;
        bus.leds      = bus.dado_memoria;
      end
      APAGA:   bus.db_estado = 4'h3;
      AVANCA:  bus.db_estado = 4'h4;
      FIM:     bus.db_estado = 4'h5;
      default: bus.db_estado = 4'hF;
    endcase
  end

  assign bus.endereco = endereco;
  assign bus.ocupado  = (estado != OCIOSO);
  assign bus.pronto   = (estado == FIM);
endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia with T_LIGA=3, T_DESLIGA=2: the expected busy-cycle
// trace is queued per run and a negedge monitor pops one entry per busy cycle.
module tb_exibe_sequencia;
  localparam int BIG = 1000;

  logic clock;
  logic reset;
  logic [3:0] mem [16];

  exibe_sequencia_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  exibe_sequencia #(
    .T_LIGA(3), .T_DESLIGA(2), .ADDR_W(4), .DATA_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  assign bus.dado_memoria = mem[bus.endereco];

  typedef struct {
    int leds;
    int endr;
    int pronto;
    int db;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int fails   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input int l, input int e, input int p, input int d,
                     inout int n, input int max_n);
    exp_t x;
    x.leds = l; x.endr = e; x.pronto = p; x.db = d;
    if (n < max_n) begin
      q.push_back(x);
      n++;
    end
  endtask

  // start_end < 0 means endereco during carrega is not checked.
  task automatic push_run(input int lim, input int start_end, input int max_n);
    int n;
    n = 0;
    add(0, start_end, 0, 1, n, max_n);
    for (int k = 0; k <= lim; k++) begin
      for (int t = 0; t < 3; t++) add(int'(mem[k]), k, 0, 2, n, max_n);
      for (int t = 0; t < 2; t++) add(0, k, 0, 3, n, max_n);
      if (k < lim) add(0, k, 0, 4, n, max_n);
    end
    add(0, lim, 1, 5, n, max_n);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.ocupado) begin
      vectors++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_busy: got db_estado=%0d leds=%0d, expected idle",
                 bus.db_estado, bus.leds);
      end else begin
        e = q.pop_front();
        if (bus.leds !== 4'(e.leds) || bus.pronto !== 1'(e.pronto) ||
            bus.db_estado !== 4'(e.db) || (e.endr >= 0 && bus.endereco !== 4'(e.endr))) begin
          fails++;
          $display("FAIL trace @%0t: got leds=%0d end=%0d pronto=%0d db=%0d, expected leds=%0d end=%0d pronto=%0d db=%0d",
                   $time, bus.leds, bus.endereco, bus.pronto, bus.db_estado,
                   e.leds, e.endr, e.pronto, e.db);
        end
      end
    end else if (!reset && bus.pronto) begin
      vectors++;
      fails++;
      $display("FAIL pronto_idle: got pronto=1 while idle, expected 0");
    end
  end

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while ((q.size() != 0 || bus.ocupado) && c < 2000) begin
      @(negedge clock);
      c++;
    end
    chk({nm, "_timeout"}, (c < 2000) ? 1 : 0, 1);
  endtask

  task automatic pulse_iniciar();
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_leds"},     int'(bus.leds), 0);
    chk({nm, "_ocupado"},  int'(bus.ocupado), 0);
    chk({nm, "_pronto"},   int'(bus.pronto), 0);
    chk({nm, "_db"},       int'(bus.db_estado), 0);
    chk({nm, "_endereco"}, int'(bus.endereco), 0);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.parar   = 1'b0;
    bus.limite  = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clock);

    // 1: four items, limite=3
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    bus.limite = 4'd3;
    push_run(3, 0, BIG);
    pulse_iniciar();
    wait_idle("t1");
    chk("t1_endereco_final", int'(bus.endereco), 3);

    // 2: single item, limite=0
    mem[0] = 4'd5;
    bus.limite = 4'd0;
    push_run(0, 3, BIG);
    pulse_iniciar();
    wait_idle("t2");
    chk("t2_endereco_final", int'(bus.endereco), 0);

    // 3: full memory, no wrap
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    bus.limite = 4'd15;
    push_run(15, 0, BIG);
    pulse_iniciar();
    wait_idle("t3");
    chk("t3_endereco_final", int'(bus.endereco), 15);

    // 4: iniciar held, limite changed mid-run
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    bus.limite = 4'd3;
    push_run(3, 15, BIG);
    push_run(1, 3, BIG);
    bus.iniciar = 1'b1;
    repeat (3) @(negedge clock);
    bus.limite = 4'd1;
    c = 0;
    while (!bus.pronto && c < 200) begin
      @(negedge clock);
      c++;
    end
    chk("t4_first_pronto_seen", (c < 200) ? 1 : 0, 1);
    @(negedge clock);
    chk("t4_gap_ocupado", int'(bus.ocupado), 0);
    @(negedge clock);
    chk("t4_restart_db", int'(bus.db_estado), 1);
    bus.iniciar = 1'b0;
    wait_idle("t4");
    chk("t4_endereco_final", int'(bus.endereco), 1);

    // 5a: parar together with iniciar in ocioso
    bus.iniciar = 1'b1;
    bus.parar   = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    bus.parar   = 1'b0;
    chk("t5_parar_iniciar_ocupado", int'(bus.ocupado), 0);

    // 5b: parar in the 2nd lit cycle of item 1
    bus.limite = 4'd3;
    push_run(3, 1, 9);
    pulse_iniciar();
    repeat (8) @(negedge clock);
    bus.parar = 1'b1;
    @(negedge clock);
    bus.parar = 1'b0;
    chk("t5_abort_ocupado", int'(bus.ocupado), 0);
    chk("t5_abort_leds",    int'(bus.leds), 0);
    chk("t5_abort_pronto",  int'(bus.pronto), 0);
    chk("t5_abort_db",      int'(bus.db_estado), 0);
    chk("t5_abort_queue",   q.size(), 0);
    push_run(3, -1, BIG);
    pulse_iniciar();
    wait_idle("t5");
    chk("t5_endereco_final", int'(bus.endereco), 3);

    // 6: async reset during apaga
    push_run(3, 3, 5);
    pulse_iniciar();
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1 chk_reset_vals("t6_async");
    chk("t6_queue", q.size(), 0);
    @(negedge clock);
    reset = 1'b0;
    bus.limite = 4'd0;
    push_run(0, 0, BIG);
    pulse_iniciar();
    wait_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1);
  end
endmodule
